exhaustive_sweep_checker: RTL and testbench

- Hardware successor to the exhaustive truth-table testbenches used for the combinational exercises.
- Sweeps every value of an N_IN-bit input vector into a combinational DUT and waits SETTLE cycles per vector.
- Compares the DUT response against a golden-model response, counts mismatches and latches the first failing vector.
- Sits between a combinational DUT/golden pair and board LEDs or a UART reporter; also usable in simulation as a self-checking bench core.

---
 rtl/sweep_pkg.sv | 18 +
 rtl/settle_counter.sv | 36 +++
 rtl/exhaustive_sweep_checker.sv | 155 +++++++++++++++
 tb/tb_exhaustive_sweep_checker.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared definitions for the exhaustive sweep checker: FSM state encoding and
// the vector-count helper.
package sweep_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StCheck,
        StHold,
        StDone
    } sweep_state_e;

    // Number of distinct stimulus vectors for an n_in-bit sweep.
    function automatic int unsigned num_vec(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/settle_counter.sv
// Down-counter loaded with SETTLE; expire is high on the last of SETTLE
// enabled cycles after a load.
module settle_counter #(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int unsigned CntW = $clog2(SETTLE + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CntW'(SETTLE);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == CntW'(1));

endmodule

// File: rtl/exhaustive_sweep_checker.sv
// Sweeps every N_IN-bit vector into a combinational DUT/golden pair, counts
// response mismatches and records the first failing vector.
module exhaustive_sweep_checker
    import sweep_pkg::*;
#(
    parameter int unsigned N_IN   = 6,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    output logic [N_IN-1:0]  vec,
    input  logic [N_OUT-1:0] dut_resp,
    input  logic [N_OUT-1:0] gold_resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_cnt,
    output logic             first_fail_valid,
    output logic [N_IN-1:0]  first_fail_vec
);

    localparam logic [N_IN-1:0] VecLast = N_IN'(num_vec(N_IN) - 1);
    localparam logic [N_IN-1:0] VecOne  = N_IN'(1);
    localparam logic [N_IN:0]   ErrOne  = (N_IN + 1)'(1);

    sweep_state_e     state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [N_IN:0]    err_cnt_q, err_cnt_d;
    logic             ff_valid_q, ff_valid_d;
    logic [N_IN-1:0]  ff_vec_q, ff_vec_d;
    logic             step_mode_q, step_mode_d;

    logic             cnt_load;
    logic             cnt_expire;
    logic             mismatch;

    settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (cnt_load),
        .en     (state_q == StApply),
        .expire (cnt_expire)
    );

    assign mismatch = (dut_resp != gold_resp);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        ff_valid_d  = ff_valid_q;
        ff_vec_d    = ff_vec_q;
        step_mode_d = step_mode_q;
        cnt_load    = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StApply;
                    vec_d       = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_cnt_d   = '0;
                    ff_valid_d  = 1'b0;
                    ff_vec_d    = '0;
                    step_mode_d = step_mode;
                    cnt_load    = 1'b1;
                end
            end
            StApply: begin
                if (cnt_expire) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    err_cnt_d = err_cnt_q + ErrOne;
                    if (!ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_vec_d   = vec_q;
                    end
                end
                if (vec_q == VecLast) begin
                    // pass must be valid on the same edge that raises done
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end else if (step_mode_q) begin
                    state_d = StHold;
                end else begin
                    state_d  = StApply;
                    vec_d    = vec_q + VecOne;
                    cnt_load = 1'b1;
                end
            end
            StHold: begin
                if (step) begin
                    state_d  = StApply;
                    vec_d    = vec_q + VecOne;
                    cnt_load = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            vec_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            ff_valid_q  <= 1'b0;
            ff_vec_q    <= '0;
            step_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            ff_valid_q  <= ff_valid_d;
            ff_vec_q    <= ff_vec_d;
            step_mode_q <= step_mode_d;
        end
    end

    assign vec              = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_cnt          = err_cnt_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_vec   = ff_vec_q;

endmodule

// File: tb/tb_exhaustive_sweep_checker.sv
// Directed bench: free-running and single-step sweeps, fault injection,
// ignored restart and asynchronous mid-sweep reset.
module tb_exhaustive_sweep_checker;

    logic clk;
    logic rst_n;

    // Instance A: N_IN=3, SETTLE=2
    logic       start3;
    logic [2:0] vec3;
    logic [1:0] dut3, gold3;
    logic       busy3, done3, pass3, ffv3;
    logic [3:0] err3;
    logic [2:0] ffvec3;
    int         fault_mode;

    // Instance B: N_IN=2, SETTLE=1, step mode
    logic       start2, step_mode2, step2;
    logic [1:0] vec2;
    logic [1:0] dut2, gold2;
    logic       busy2, done2, pass2, ffv2;
    logic [2:0] err2;
    logic [1:0] ffvec2;

    int n_vec;
    int n_miss;

    exhaustive_sweep_checker #(
        .N_IN   (3),
        .N_OUT  (2),
        .SETTLE (2)
    ) u_dut3 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start3),
        .step_mode        (1'b0),
        .step             (1'b0),
        .vec              (vec3),
        .dut_resp         (dut3),
        .gold_resp        (gold3),
        .busy             (busy3),
        .done             (done3),
        .pass             (pass3),
        .err_cnt          (err3),
        .first_fail_valid (ffv3),
        .first_fail_vec   (ffvec3)
    );

    exhaustive_sweep_checker #(
        .N_IN   (2),
        .N_OUT  (2),
        .SETTLE (1)
    ) u_dut2 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start2),
        .step_mode        (step_mode2),
        .step             (step2),
        .vec              (vec2),
        .dut_resp         (dut2),
        .gold_resp        (gold2),
        .busy             (busy2),
        .done             (done2),
        .pass             (pass2),
        .err_cnt          (err2),
        .first_fail_valid (ffv2),
        .first_fail_vec   (ffvec2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        gold3 = vec3[1:0];
        dut3  = vec3[1:0];
        if (fault_mode == 1 && (vec3 == 3'd5 || vec3 == 3'd6)) begin
            dut3 = vec3[1:0] ^ 2'b01;
        end else if (fault_mode == 2) begin
            dut3 = ~vec3[1:0];
        end
        gold2 = vec2;
        dut2  = vec2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one free-running sweep on instance A; optional restart attempt at restart_cyc.
    task automatic sweep3(input int restart_cyc, input int exp_err, input int exp_ffv,
                          input int exp_ffvec);
        int cyc;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        cyc = 0;
        while (busy3 === 1'b1 && cyc < 100) begin
            if (cyc % 3 == 0) check("vec3_seq", 32'(vec3), 32'(cyc / 3));
            start3 = (cyc == restart_cyc);
            tick();
            cyc++;
        end
        start3 = 1'b0;
        check("busy_cycles", 32'(cyc), 32'd24);
        check("done3", 32'(done3), 32'd1);
        check("pass3", 32'(pass3), (exp_err == 0) ? 32'd1 : 32'd0);
        check("err3", 32'(err3), 32'(exp_err));
        check("ffv3", 32'(ffv3), 32'(exp_ffv));
        check("ffvec3", 32'(ffvec3), 32'(exp_ffvec));
        check("vec3_end", 32'(vec3), 32'd7);
    endtask

    initial begin
        int cyc;
        n_vec      = 0;
        n_miss     = 0;
        fault_mode = 0;
        rst_n      = 1'b0;
        start3     = 1'b0;
        start2     = 1'b0;
        step_mode2 = 1'b0;
        step2      = 1'b0;
        #22 rst_n = 1'b1;
        tick();

        check("rst_vec3", 32'(vec3), 32'd0);
        check("rst_busy3", 32'(busy3), 32'd0);
        check("rst_done3", 32'(done3), 32'd0);
        check("rst_pass3", 32'(pass3), 32'd0);
        check("rst_err3", 32'(err3), 32'd0);
        check("rst_ffv3", 32'(ffv3), 32'd0);
        check("rst_done2", 32'(done2), 32'd0);

        // Clean sweep
        sweep3(-1, 0, 0, 0);
        // Faults at vectors 5 and 6
        fault_mode = 1;
        sweep3(-1, 2, 1, 5);
        // All vectors fail: count saturates exactly at 2^N_IN
        fault_mode = 2;
        sweep3(-1, 8, 1, 0);
        // Restart attempt at vec=3 (cycle 9) must be ignored
        fault_mode = 0;
        sweep3(9, 0, 0, 0);

        // Asynchronous reset mid-sweep with errors already accumulated
        fault_mode = 2;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        cyc = 0;
        while (vec3 !== 3'd4 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("reach_vec4", 32'(vec3), 32'd4);
        check("err_before_rst", 32'(err3), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vec3", 32'(vec3), 32'd0);
        check("arst_busy3", 32'(busy3), 32'd0);
        check("arst_err3", 32'(err3), 32'd0);
        check("arst_ffv3", 32'(ffv3), 32'd0);
        check("arst_ffvec3", 32'(ffvec3), 32'd0);
        check("arst_done3", 32'(done3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        fault_mode = 0;
        sweep3(-1, 0, 0, 0);

        // Single-step sweep on instance B
        start2     = 1'b1;
        step_mode2 = 1'b1;
        tick();
        start2     = 1'b0;
        step_mode2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("step_vec_apply", 32'(vec2), 32'(k));
            tick();
            tick();
            if (k < 3) begin
                repeat (10) tick();
                check("hold_vec", 32'(vec2), 32'(k));
                check("hold_busy", 32'(busy2), 32'd1);
                check("hold_done", 32'(done2), 32'd0);
                step2 = 1'b1;
                tick();
                step2 = 1'b0;
            end else begin
                check("step_done", 32'(done2), 32'd1);
                check("step_busy", 32'(busy2), 32'd0);
                check("step_pass", 32'(pass2), 32'd1);
                check("step_vec_end", 32'(vec2), 32'd3);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
